rgmii_rx_framer: RTL and testbench

- Second-generation RGMII receive front end, clocked by rx_clk.
- Takes the already DDR-captured control and data pair and decodes in-band link status with a debounce filter.
- Assembles bytes in 1000M (byte per clock) or 10/100M (nibble per clock) mode, strips preamble/SFD and emits a framed byte stream with start/end/error markers plus frame statistics.
- Sits between the DDR capture stage and the MAC receive FIFO.

---
 rtl/rgmii_pkg.sv | 17 +
 rtl/rgmii_link_status.sv | 50 +++++
 rtl/rgmii_rx_framer.sv | 180 ++++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path: speed codes, framing bytes
// and the receive FSM state encoding.
package rgmii_pkg;
  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_e;
endpackage

// File: rtl/rgmii_link_status.sv
// In-band RGMII link status decode with a consecutive-sample debounce filter
// and a one-cycle pulse whenever the committed status changes.
module rgmii_link_status #(
  parameter int LINK_STABLE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_ctl,
  input  logic [7:0] i_data,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_link_full_duplex,
  output logic       o_link_change
);
  localparam int CW = $clog2(LINK_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(LINK_STABLE_CYCLES);

  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic          w_sample;
  logic [CW-1:0] w_cnt_nxt;

  // Both DDR nibbles must agree; speed code 11 is not a legal status.
  assign w_sample = (i_ctl == 2'b00) && (i_data[3:0] == i_data[7:4]) &&
                    (i_data[2:1] != 2'b11);
  assign w_cnt_nxt = (i_data[3:0] != r_cand) ? CW'(1) :
                     (r_cnt == STABLE)       ? STABLE : r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand             <= '0;
      r_cnt              <= '0;
      o_link_up          <= 1'b0;
      o_link_speed       <= 2'b00;
      o_link_full_duplex <= 1'b0;
      o_link_change      <= 1'b0;
    end else begin
      o_link_change <= 1'b0;
      if (w_sample) begin
        r_cand <= i_data[3:0];
        r_cnt  <= w_cnt_nxt;
        if (w_cnt_nxt == STABLE) begin
          {o_link_full_duplex, o_link_speed, o_link_up} <= i_data[3:0];
          o_link_change <= (i_data[3:0] !=
                            {o_link_full_duplex, o_link_speed, o_link_up});
        end
      end
    end
  end
endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: byte/nibble assembly, preamble/SFD stripping, framed
// byte stream with sof/eof/err markers and saturating frame statistics.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int LINK_STABLE_CYCLES = 8,
  parameter int MAX_FRAME_BYTES    = 1522,
  parameter int CNT_W              = 16
) (
  input  logic             rx_clk,
  input  logic             rst_n,
  input  logic [1:0]       raw_ctl,
  input  logic [7:0]       raw_data,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_full_duplex,
  output logic             link_change,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic             m_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int BC_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [BC_W-1:0] MAX_BYTES = BC_W'(MAX_FRAME_BYTES);

  logic [1:0]      r_ctl;
  logic [7:0]      r_data;
  logic            w_dv, w_er;
  rx_state_e       r_state, w_state_nxt;
  logic            r_nib, r_half;
  logic [3:0]      r_lo;
  logic            w_byte_vld;
  logic [7:0]      w_byte;
  logic [7:0]      r_hold;
  logic            r_have, r_first, r_err;
  logic [BC_W-1:0] r_bcnt;
  logic            w_emit, w_eof, w_err_out, w_load, w_start;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl  <= 2'b00;
      r_data <= 8'h00;
    end else begin
      r_ctl  <= raw_ctl;
      r_data <= raw_data;
    end
  end

  assign w_dv = r_ctl[0];
  assign w_er = r_ctl[0] ^ r_ctl[1];

  rgmii_link_status #(
    .LINK_STABLE_CYCLES(LINK_STABLE_CYCLES)
  ) u_link (
    .i_clk             (rx_clk),
    .i_rst_n           (rst_n),
    .i_ctl             (r_ctl),
    .i_data            (r_data),
    .o_link_up         (link_up),
    .o_link_speed      (link_speed),
    .o_link_full_duplex(link_full_duplex),
    .o_link_change     (link_change)
  );

  // Mode only follows link status between frames, never mid-frame.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib  <= 1'b0;
      r_half <= 1'b0;
      r_lo   <= 4'h0;
    end else begin
      if (r_state == IDLE && !w_dv) r_nib <= link_up && (link_speed != SPD_1000);
      if (!w_dv) begin
        r_half <= 1'b0;
      end else if (r_nib) begin
        r_half <= !r_half;
        if (!r_half) r_lo <= r_data[3:0];
      end
    end
  end

  assign w_byte_vld = w_dv && (!r_nib || r_half);
  assign w_byte     = r_nib ? {r_data[3:0], r_lo} : r_data;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_eof       = 1'b0;
    w_err_out   = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: if (w_dv) w_state_nxt = PREAMBLE;
      PREAMBLE: begin
        if (!w_dv) begin
          w_state_nxt = IDLE;
        end else if (w_byte_vld) begin
          if (w_byte == SFD_BYTE) begin
            w_state_nxt = DATA;
            w_start     = 1'b1;
          end else if (w_byte != PREAMBLE_BYTE) begin
            w_state_nxt = DROP;
          end
        end
      end
      DATA: begin
        // A pending low nibble at dv fall means the frame ended misaligned.
        if (!w_dv) begin
          w_state_nxt = IDLE;
          w_emit      = r_have;
          w_eof       = r_have;
          w_err_out   = r_err | r_half;
        end else if (w_byte_vld) begin
          w_emit = r_have;
          if (r_bcnt == MAX_BYTES) begin
            w_eof       = r_have;
            w_err_out   = 1'b1;
            w_state_nxt = DROP;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      DROP: if (!w_dv) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 8'h00;
      r_have      <= 1'b0;
      r_first     <= 1'b0;
      r_err       <= 1'b0;
      r_bcnt      <= '0;
      m_data      <= 8'h00;
      m_valid     <= 1'b0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_err       <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (w_start) begin
        r_have  <= 1'b0;
        r_first <= 1'b1;
        r_err   <= 1'b0;
        r_bcnt  <= '0;
      end else if (r_state == DATA) begin
        if (w_dv && w_er) r_err <= 1'b1;
        if (w_load) begin
          r_hold <= w_byte;
          r_have <= 1'b1;
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (w_emit) r_first <= 1'b0;
      end
      m_valid <= w_emit;
      m_data  <= w_emit ? r_hold : 8'h00;
      m_sof   <= w_emit & r_first;
      m_eof   <= w_eof;
      m_err   <= w_eof & w_err_out;
      if (w_eof) begin
        if (w_err_out) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
        end else begin
          if (frame_count != '1) frame_count <= frame_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed bench for rgmii_rx_framer: link-status debounce table plus
// hand-built frame sequences in 1000M and 100M modes.
module tb_rgmii_rx_framer;
  logic        rx_clk;
  logic        rst_n;
  logic [1:0]  raw_ctl;
  logic [7:0]  raw_data;
  logic        link_up;
  logic [1:0]  link_speed;
  logic        link_full_duplex;
  logic        link_change;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof, m_err;
  logic [15:0] frame_count, err_count;

  rgmii_rx_framer #(
    .LINK_STABLE_CYCLES(8),
    .MAX_FRAME_BYTES   (1522),
    .CNT_W             (16)
  ) dut (
    .rx_clk          (rx_clk),
    .rst_n           (rst_n),
    .raw_ctl         (raw_ctl),
    .raw_data        (raw_data),
    .link_up         (link_up),
    .link_speed      (link_speed),
    .link_full_duplex(link_full_duplex),
    .link_change     (link_change),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_sof           (m_sof),
    .m_eof           (m_eof),
    .m_err           (m_err),
    .frame_count     (frame_count),
    .err_count       (err_count)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [1:0] ctl;
    logic [7:0] data;
    logic       up;
    logic [1:0] spd;
    logic       dup;
    logic       chg;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } beat_t;

  vec_t  tbl[$];
  beat_t q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_bad = 0;
  int    exp_f = 0;
  int    exp_e = 0;
  logic [7:0] status = 8'hDD;

  always @(posedge rx_clk) begin
    #1;
    cyc++;
    if (m_valid) q.push_back('{m_data, m_sof, m_eof, m_err, cyc});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] d);
    @(negedge rx_clk);
    raw_ctl  = c;
    raw_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, status);
  endtask

  task automatic add(input int n, input logic [7:0] d, input logic up,
                     input logic [1:0] spd, input logic dup, input logic chg);
    for (int i = 0; i < n; i++) tbl.push_back('{2'b00, d, up, spd, dup, chg});
  endtask

  // Preamble, SFD, then payload bytes 1,2,3,... ; er_idx marks one errored byte.
  task automatic send_frame(input bit nib, input int nbytes, input int er_idx, input bit odd);
    logic [7:0] fr[$];
    logic [1:0] c;
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < nbytes; i++) fr.push_back(8'(i + 1));
    for (int k = 0; k < fr.size(); k++) begin
      c = (k - 8 == er_idx) ? 2'b01 : 2'b11;
      if (nib) begin
        drive(c, {fr[k][3:0], fr[k][3:0]});
        drive(c, {fr[k][7:4], fr[k][7:4]});
      end else begin
        drive(c, fr[k]);
      end
    end
    if (odd) drive(2'b11, 8'h77);
  endtask

  task automatic check_frame(input string nm, input int n, input int step, input bit err);
    int bad_d = 0;
    int bad_f = 0;
    int bad_s = 0;
    chk({nm, " beats"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].d !== 8'(i + 1)) bad_d++;
      if (q[i].sof !== (i == 0) || q[i].eof !== (i == q.size() - 1)) bad_f++;
      if (q[i].err !== (err && i == q.size() - 1)) bad_f++;
      if (i > 0 && i < q.size() - 1 && q[i].cyc - q[i-1].cyc != step) bad_s++;
    end
    chk({nm, " data errors"}, 64'(bad_d), 64'd0);
    chk({nm, " marker errors"}, 64'(bad_f), 64'd0);
    chk({nm, " spacing errors"}, 64'(bad_s), 64'd0);
    chk({nm, " counters"}, {32'(frame_count), 32'(err_count)}, {32'(exp_f), 32'(exp_e)});
  endtask

  initial begin
    int neof;
    rst_n    = 1'b0;
    raw_ctl  = 2'b00;
    raw_data = 8'h00;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("reset outputs", 64'({link_up, link_speed, link_full_duplex, link_change, m_data,
        m_valid, m_sof, m_eof, m_err, frame_count, err_count}), 64'd0);
    @(negedge rx_clk);
    rst_n = 1'b1;

    // Debounce table: each row is one status cycle and the link outputs it produces.
    add(7, 8'hDD, 1'b0, 2'b00, 1'b0, 1'b0);
    add(1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b1);
    add(1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b0);
    add(1, 8'hD5, 1'b1, 2'b10, 1'b1, 1'b0);
    add(2, 8'h77, 1'b1, 2'b10, 1'b1, 1'b0);
    add(7, 8'hBB, 1'b1, 2'b10, 1'b1, 1'b0);
    add(1, 8'h77, 1'b1, 2'b10, 1'b1, 1'b0);
    add(1, 8'hBB, 1'b1, 2'b01, 1'b1, 1'b1);
    add(1, 8'hBB, 1'b1, 2'b01, 1'b1, 1'b0);
    add(5, 8'hDD, 1'b1, 2'b01, 1'b1, 1'b0);
    add(1, 8'hBB, 1'b1, 2'b01, 1'b1, 1'b0);
    add(7, 8'hDD, 1'b1, 2'b01, 1'b1, 1'b0);
    add(1, 8'hDD, 1'b1, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) drive(tbl[i].ctl, tbl[i].data);
      else                drive(2'b00, 8'hDD);
      @(posedge rx_clk);
      #1;
      if (i >= 1)
        chk($sformatf("link vec %0d", i - 1),
            64'({link_up, link_speed, link_full_duplex, link_change}),
            64'({tbl[i-1].up, tbl[i-1].spd, tbl[i-1].dup, tbl[i-1].chg}));
    end

    status = 8'hDD;
    idle(4);
    q.delete();
    send_frame(1'b0, 64, -1, 1'b0);
    idle(6);
    exp_f++;
    check_frame("1000M frame", 64, 1, 1'b0);

    // 100M status commits right as the frame starts: this frame stays byte mode.
    repeat (8) drive(2'b00, 8'hBB);
    status = 8'hBB;
    q.delete();
    send_frame(1'b0, 64, -1, 1'b0);
    idle(6);
    exp_f++;
    check_frame("speed change frame", 64, 1, 1'b0);
    chk("speed after change", 64'(link_speed), 64'(2'b01));

    idle(4);
    q.delete();
    send_frame(1'b1, 64, -1, 1'b0);
    idle(6);
    exp_f++;
    check_frame("100M frame", 64, 2, 1'b0);

    q.delete();
    send_frame(1'b1, 10, -1, 1'b1);
    idle(6);
    exp_e++;
    check_frame("odd nibble frame", 10, 2, 1'b1);

    status = 8'hDD;
    idle(12);
    q.delete();
    send_frame(1'b0, 64, 19, 1'b0);
    idle(6);
    exp_e++;
    check_frame("er frame", 64, 1, 1'b1);

    q.delete();
    send_frame(1'b0, 1530, -1, 1'b0);
    idle(6);
    exp_e++;
    check_frame("oversize frame", 1522, 1, 1'b1);

    q.delete();
    send_frame(1'b0, 1, -1, 1'b0);
    idle(6);
    exp_f++;
    check_frame("one byte frame", 1, 1, 1'b0);

    // Reset in the middle of a frame: everything clears and no eof follows.
    q.delete();
    repeat (7) drive(2'b11, 8'h55);
    drive(2'b11, 8'hD5);
    for (int i = 0; i < 10; i++) drive(2'b11, 8'(i + 1));
    @(posedge rx_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset outputs", 64'({link_up, link_speed, link_full_duplex, link_change,
        m_data, m_valid, m_sof, m_eof, m_err, frame_count, err_count}), 64'd0);
    drive(2'b00, 8'hDD);
    drive(2'b00, 8'hDD);
    rst_n = 1'b1;
    idle(6);
    neof = 0;
    for (int i = 0; i < q.size(); i++) if (q[i].eof) neof++;
    chk("eof after mid-frame reset", 64'(neof), 64'd0);
    chk("counters after reset", {32'(frame_count), 32'(err_count)}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
